// File: rtl/as_alu_ctrl.sv
// rtl/as_alu_ctrl.sv - ALU control sequencer: start/done ops, MACC term loop, synchronized key input.
// Define AS_ALU_CTRL_ABORT_EN to let `abort` cancel MACC and WAIT_IN with a done+err pulse.
module as_alu_ctrl #(
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   op,
  input  logic [n-1:0] count,
  input  logic         key,
  input  logic         z,
  input  logic         abort,
  output logic         add_a_sel,
  output logic         add_b_sel,
  output logic         acc_en,
  output logic         acc_add,
  output logic         in_en,
  output logic         reg_we,
  output logic [n-1:0] idx,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         sw_zero
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_ADD   = 3'b001;
  localparam logic [2:0] OP_ADDI  = 3'b010;
  localparam logic [2:0] OP_LDACC = 3'b011;
  localparam logic [2:0] OP_MACC  = 3'b100;
  localparam logic [2:0] OP_IN    = 3'b101;
  localparam logic [2:0] OP_TSTSW = 3'b110;
  localparam logic [2:0] OP_RSVD  = 3'b111;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_EXEC    = 3'd1,
    ST_MACC    = 3'd2,
    ST_WAIT_IN = 3'd3,
    ST_IN_WB   = 3'd4,
    ST_ABORT   = 3'd5
  } state_t;

  state_t       state_q, state_d;
  logic [2:0]   op_q, op_d;
  logic [n-1:0] count_q, count_d;
  logic [n-1:0] idx_q, idx_d;
  logic         sw_zero_q, sw_zero_d;
  logic         key_s1_q, key_s2_q, key_prev_q;
  logic         key_rise;
  logic         macc_last;
  logic         abort_req;

`ifdef AS_ALU_CTRL_ABORT_EN
  assign abort_req = abort;
`else
  logic unused_abort;
  assign unused_abort = abort;
  assign abort_req    = 1'b0;
`endif

  // The previous-value flop makes a key already high on WAIT_IN entry look level, not an edge.
  assign key_rise  = key_s2_q & ~key_prev_q;
  assign macc_last = (idx_q == count_q - {{(n-1){1'b0}}, 1'b1});

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      count_q    <= '0;
      idx_q      <= '0;
      sw_zero_q  <= 1'b0;
      key_s1_q   <= 1'b0;
      key_s2_q   <= 1'b0;
      key_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      sw_zero_q  <= sw_zero_d;
      key_s1_q   <= key;
      key_s2_q   <= key_s1_q;
      key_prev_q <= key_s2_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    count_d   = count_q;
    idx_d     = idx_q;
    sw_zero_d = sw_zero_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          op_d    = op;
          count_d = count;
          idx_d   = '0;
          if (op == OP_MACC && count != '0) state_d = ST_MACC;
          else if (op == OP_IN)             state_d = ST_WAIT_IN;
          else                              state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        state_d = ST_IDLE;
        if (op_q == OP_TSTSW) sw_zero_d = z;
      end
      ST_MACC: begin
        // Completion wins over abort so the last term never yields a second done.
        if (macc_last) begin
          state_d = ST_IDLE;
          idx_d   = '0;
        end else if (abort_req) begin
          state_d = ST_ABORT;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + {{(n-1){1'b0}}, 1'b1};
        end
      end
      ST_WAIT_IN: begin
        if (key_rise)       state_d = ST_IN_WB;
        else if (abort_req) state_d = ST_ABORT;
      end
      ST_IN_WB: state_d = ST_IDLE;
      ST_ABORT: state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    add_a_sel = 1'b0;
    add_b_sel = 1'b0;
    acc_en    = 1'b0;
    acc_add   = 1'b0;
    in_en     = 1'b0;
    reg_we    = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    busy      = (state_q != ST_IDLE);
    unique case (state_q)
      ST_EXEC: begin
        done = 1'b1;
        case (op_q)
          OP_ADD: reg_we = 1'b1;
          OP_ADDI: begin
            add_b_sel = 1'b1;
            reg_we    = 1'b1;
          end
          OP_LDACC: begin
            add_b_sel = 1'b1;
            acc_en    = 1'b1;
          end
          OP_TSTSW: add_a_sel = 1'b1;
          OP_RSVD:  err       = 1'b1;
          default: ;
        endcase
      end
      ST_MACC: begin
        acc_en  = 1'b1;
        acc_add = 1'b1;
        done    = macc_last;
      end
      ST_IN_WB: begin
        in_en  = 1'b1;
        reg_we = 1'b1;
        done   = 1'b1;
      end
      ST_ABORT: begin
        done = 1'b1;
        err  = 1'b1;
      end
      default: ;
    endcase
  end

  assign idx     = idx_q;
  assign sw_zero = sw_zero_q;

endmodule
